// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial operand transmitter.
// Used by the transmitter top and its shift-register lanes.
package serial_cmp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    localparam int DEFAULT_W = 8;

endpackage

// File: rtl/serial_shift_reg.sv
// W-bit loadable shift register that presents one serial bit per position.
// Direction is fixed at elaboration: MSB_FIRST shifts left, otherwise right.
module serial_shift_reg
    import serial_cmp_pkg::*;
#(
    parameter int W         = DEFAULT_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // The serial bit is a register bit, so there is no path from din to dout.
    assign dout = MSB_FIRST ? sr_q[W-1] : sr_q[0];

endmodule

// File: rtl/serial_operand_transmitter.sv
// Serialises a parallel operand pair into bit pairs with first/last markers.
// A new pair may be accepted on the last bit so words stream without bubbles.
module serial_operand_transmitter
    import serial_cmp_pkg::*;
#(
    parameter int W         = DEFAULT_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_a,
    output logic         out_b,
    output logic         out_first,
    output logic         out_last
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    tx_state_t     state_q;
    tx_state_t     state_d;
    logic          valid_q;
    logic          valid_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic          load;
    logic          shift;
    logic          accept;
    logic          advance;

    assign out_valid = valid_q;
    assign out_first = valid_q & (idx_q == '0);
    assign out_last  = valid_q & (idx_q == LAST_IDX);
    assign in_ready  = (state_q == IDLE) | (out_last & out_ready);
    assign accept    = in_valid & in_ready;
    assign advance   = valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                if (advance) begin
                    if (!out_last) begin
                        shift = 1'b1;
                        idx_d = idx_q + 1'b1;
                    end else if (accept) begin
                        load  = 1'b1;
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    serial_shift_reg #(
        .W        (W),
        .MSB_FIRST(MSB_FIRST)
    ) u_sr_a (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .shift(shift),
        .din  (in_a),
        .dout (out_a)
    );

    serial_shift_reg #(
        .W        (W),
        .MSB_FIRST(MSB_FIRST)
    ) u_sr_b (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .shift(shift),
        .din  (in_b),
        .dout (out_b)
    );

endmodule
